// File: rtl/eer_pkg.sv
// Shared EER node types: packet codes, requester indices and transmit-scheduler states.
package eer_pkg;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned NumReq     = 4;

    typedef enum logic [2:0] {
        PktHb   = 3'b000,
        PktChe  = 3'b001,
        PktInv  = 3'b010,
        PktMr   = 3'b011,
        PktCht  = 3'b100,
        PktData = 3'b101,
        PktSos  = 3'b110
    } pktType_e;

    localparam int unsigned ReqSos  = 0;
    localparam int unsigned ReqData = 1;
    localparam int unsigned ReqMr   = 2;
    localparam int unsigned ReqCtrl = 3;

    typedef enum logic [2:0] {
        StIdle,
        StSense,
        StBackoff,
        StSend,
        StDone
    } schedState_e;

    // Lowest set bit wins, giving fixed priority 0 > 1 > 2 > 3.
    function automatic logic [NumReq-1:0] pickLowest(input logic [NumReq-1:0] vec);
        return vec & (~vec + NumReq'(1));
    endfunction

endpackage

// File: rtl/slot_timer.sv
// TDMA slot timer: cycle and slot counters, first-cycle-of-slot tick and the open
// (pre-guard) window flag. Counters are held at zero outside the communication phase.
module slot_timer #(
    parameter int unsigned WORD_WIDTH   = 16,
    parameter int unsigned SLOT_CYCLES  = 32,
    parameter int unsigned NUM_SLOTS    = 16,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  commPhase,
    output logic [WORD_WIDTH-1:0] curSlot,
    output logic                  slotTick,
    output logic                  guardOpen
);

    localparam int unsigned CycW       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned OpenCycles = SLOT_CYCLES - GUARD_CYCLES;

    logic [CycW-1:0]       cycleCnt_q;
    logic [WORD_WIDTH-1:0] curSlot_q;
    logic                  slotTick_q;
    logic                  lastCycle;

    assign lastCycle = (cycleCnt_q == CycW'(SLOT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!nrst || !commPhase) begin
            cycleCnt_q <= '0;
            curSlot_q  <= '0;
            slotTick_q <= 1'b0;
        end else begin
            slotTick_q <= lastCycle;
            if (lastCycle) begin
                cycleCnt_q <= '0;
                curSlot_q  <= (curSlot_q == WORD_WIDTH'(NUM_SLOTS - 1)) ? '0
                                                                         : curSlot_q + WORD_WIDTH'(1);
            end else begin
                cycleCnt_q <= cycleCnt_q + CycW'(1);
            end
        end
    end

    assign curSlot   = curSlot_q;
    assign slotTick  = slotTick_q;
    assign guardOpen = (32'(cycleCnt_q) < OpenCycles);

endmodule

// File: rtl/tx_scheduler.sv
// Radio transmit scheduler: fixed-priority arbitration of four requesters, TDMA gating of
// DATA, carrier sense and start/completion. Define TX_SCHED_BACKOFF_EN for backoff/retry/fail.
module tx_scheduler #(
    parameter int unsigned WORD_WIDTH   = eer_pkg::WORD_WIDTH,
    parameter int unsigned SLOT_CYCLES  = 32,
    parameter int unsigned NUM_SLOTS    = 16,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned BACKOFF_BASE = 8,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  commPhase,
    input  logic [WORD_WIDTH-1:0] myTimeslot,
    input  logic [3:0]            req,
    input  logic [2:0]            ctrlType,
    input  logic                  channel_clear,
    input  logic                  tx_done,
    output logic [3:0]            grant,
    output logic                  tx_start,
    output logic [2:0]            tx_type,
    output logic [3:0]            done,
    output logic [3:0]            fail,
    output logic [WORD_WIDTH-1:0] curSlot,
    output logic                  slotTick
);

    import eer_pkg::*;

`ifdef TX_SCHED_BACKOFF_EN
    localparam bit BackoffEn = 1'b1;
`else
    localparam bit BackoffEn = 1'b0;
`endif

    localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);
    localparam int unsigned BoW    = $clog2(MAX_RETRY * BACKOFF_BASE + 2);

    schedState_e       state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [2:0]        txType_q, txType_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [BoW-1:0]    boCnt_q, boCnt_d;
    logic              txStart_q, txStart_d;
    logic [3:0]        done_q, done_d;
    logic [3:0]        fail_q, fail_d;

    logic       guardOpen;
    logic       dataElig;
    logic [3:0] elig;
    logic [3:0] winner;
    logic       ownerAbort;

    slot_timer #(
        .WORD_WIDTH  (WORD_WIDTH),
        .SLOT_CYCLES (SLOT_CYCLES),
        .NUM_SLOTS   (NUM_SLOTS),
        .GUARD_CYCLES(GUARD_CYCLES)
    ) uSlotTimer (
        .clk      (clk),
        .nrst     (nrst),
        .commPhase(commPhase),
        .curSlot  (curSlot),
        .slotTick (slotTick),
        .guardOpen(guardOpen)
    );

    assign dataElig = commPhase && (curSlot == myTimeslot) && guardOpen;
    assign elig     = req & {2'b11, dataElig, 1'b1};
    assign winner   = pickLowest(elig);
    // Owner withdrew, or a DATA owner fell out of its slot window.
    assign ownerAbort = (|(grant_q & ~req)) || (grant_q[ReqData] && !dataElig);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            txType_q  <= PktHb;
            retry_q   <= '0;
            boCnt_q   <= '0;
            txStart_q <= 1'b0;
            done_q    <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            txType_q  <= txType_d;
            retry_q   <= retry_d;
            boCnt_q   <= boCnt_d;
            txStart_q <= txStart_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        txType_d  = txType_q;
        retry_d   = retry_q;
        boCnt_d   = boCnt_q;
        txStart_d = 1'b0;
        done_d    = '0;
        fail_d    = '0;

        case (state_q)
            StIdle: begin
                if (|elig) begin
                    state_d = StSense;
                    grant_d = winner;
                    retry_d = '0;
                    if (winner[ReqSos])       txType_d = PktSos;
                    else if (winner[ReqData]) txType_d = PktData;
                    else if (winner[ReqMr])   txType_d = PktMr;
                    else if (winner[ReqCtrl]) txType_d = ctrlType;
                end
            end
            StSense: begin
                if (ownerAbort) begin
                    state_d = StIdle;
                    grant_d = '0;
                end else if (channel_clear) begin
                    state_d   = StSend;
                    txStart_d = 1'b1;
                end else if (BackoffEn) begin
                    if (retry_q == RetryW'(MAX_RETRY)) begin
                        state_d = StIdle;
                        fail_d  = grant_q;
                        grant_d = '0;
                    end else begin
                        state_d = StBackoff;
                        boCnt_d = BoW'((32'(retry_q) + 32'd1) * BACKOFF_BASE);
                        retry_d = retry_q + RetryW'(1);
                    end
                end
            end
            StBackoff: begin
                if (ownerAbort) begin
                    state_d = StIdle;
                    grant_d = '0;
                    boCnt_d = '0;
                end else if (boCnt_q <= BoW'(1)) begin
                    state_d = StSense;
                    boCnt_d = '0;
                end else begin
                    boCnt_d = boCnt_q - BoW'(1);
                end
            end
            StSend: begin
                if (tx_done) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
                done_d  = grant_q;
                grant_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign grant    = grant_q;
    assign tx_start = txStart_q;
    assign tx_type  = txType_q;
    assign done     = done_q;
    assign fail     = fail_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: scoreboard of start/done/fail events plus directed timing checks.
module tb_tx_scheduler;

    logic        clk = 1'b0;
    logic        nrst;
    logic        commPhase;
    logic [15:0] myTimeslot;
    logic [3:0]  req;
    logic [2:0]  ctrlType;
    logic        channel_clear;
    logic        tx_done;
    logic [3:0]  grant;
    logic        tx_start;
    logic [2:0]  tx_type;
    logic [3:0]  done;
    logic [3:0]  fail;
    logic [15:0] curSlot;
    logic        slotTick;

    int errCnt = 0;
    int chkCnt = 0;
    int n;
    logic [11:0] expQ[$];

    tx_scheduler uDut (
        .clk          (clk),
        .nrst         (nrst),
        .commPhase    (commPhase),
        .myTimeslot   (myTimeslot),
        .req          (req),
        .ctrlType     (ctrlType),
        .channel_clear(channel_clear),
        .tx_done      (tx_done),
        .grant        (grant),
        .tx_start     (tx_start),
        .tx_type      (tx_type),
        .done         (done),
        .fail         (fail),
        .curSlot      (curSlot),
        .slotTick     (slotTick)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event code: kind (1 start, 2 done, 3 fail), requester vector, packet type.
    function automatic logic [11:0] mkEvt(input logic [3:0] kind, input logic [3:0] vec,
                                          input logic [2:0] typ);
        return {kind, vec, 1'b0, typ};
    endfunction

    task automatic sbCheck(input logic [11:0] obs);
        logic [11:0] exp;
        if (expQ.size() == 0) begin
            checkEq("sbUnexpected", 64'(obs), 64'd0);
        end else begin
            exp = expQ.pop_front();
            checkEq("sbEvent", 64'(obs), 64'(exp));
        end
    endtask

    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            if (tx_start) sbCheck(mkEvt(4'd1, grant, tx_type));
            if (|done)    sbCheck(mkEvt(4'd2, done, 3'd0));
            if (|fail)    sbCheck(mkEvt(4'd3, fail, 3'd0));
        end
    end

    // Expects the granted transaction to start, completes it and withdraws the request.
    task automatic serve(input logic [3:0] owner, input logic [2:0] typ, input string tag);
        int k;
        k = 0;
        while (!tx_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkEq({tag, "Start"}, {grant, tx_start, tx_type}, {owner, 1'b1, typ});
        @(negedge clk);
        tx_done = 1'b1;
        expQ.push_back(mkEvt(4'd2, owner, 3'd0));
        @(negedge clk);
        tx_done = 1'b0;
        k = 0;
        while (done == 4'd0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checkEq({tag, "DoneLat"}, 64'(k), 64'd1);
        checkEq({tag, "Done"}, {done, grant}, {owner, 4'b0000});
        req = req & ~owner;
    endtask

    initial begin
        nrst = 1'b0; commPhase = 1'b0; myTimeslot = 16'd2; req = 4'b0000;
        ctrlType = 3'b000; channel_clear = 1'b1; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("rstOut", {grant, tx_start, tx_type, done, fail, slotTick, curSlot}, 64'd0);

        // DATA waits for its own slot, then starts the cycle after grant.
        nrst = 1'b1; commPhase = 1'b1;
        expQ.push_back(mkEvt(4'd1, 4'b0010, 3'b101));
        req = 4'b0010;
        n = 0;
        while (grant == 4'd0 && n < 200) begin @(negedge clk); n++; end
        checkEq("t1Grant", grant, 4'b0010);
        checkEq("t1Slot", curSlot, 16'd2);
        checkEq("t1NoStartYet", tx_start, 1'b0);
        serve(4'b0010, 3'b101, "t1");

        // SOS and control together: SOS first, control after one idle cycle.
        @(negedge clk);
        ctrlType = 3'b010;
        expQ.push_back(mkEvt(4'd1, 4'b0001, 3'b110));
        req = 4'b1001;
        serve(4'b0001, 3'b110, "t2a");
        expQ.push_back(mkEvt(4'd1, 4'b1000, 3'b010));
        @(negedge clk);
        checkEq("t2Regrant", grant, 4'b1000);
        serve(4'b1000, 3'b010, "t2b");

        // MR on a busy channel.
        @(negedge clk);
        channel_clear = 1'b0;
`ifdef TX_SCHED_BACKOFF_EN
        expQ.push_back(mkEvt(4'd3, 4'b0100, 3'd0));
`endif
        req = 4'b0100;
        @(negedge clk);
        checkEq("t3Grant", grant, 4'b0100);
`ifdef TX_SCHED_BACKOFF_EN
        // 4 one-cycle senses plus backoffs of 8 + 16 + 24.
        n = 0;
        while (fail == 4'd0 && n < 100) begin @(negedge clk); n++; end
        checkEq("t3FailLat", 64'(n), 64'd52);
        checkEq("t3Fail", {fail, grant}, {4'b0100, 4'b0000});
        req = 4'b0000; channel_clear = 1'b1;
`else
        repeat (100) @(negedge clk);
        checkEq("t3Hold", {grant, fail}, {4'b0100, 4'b0000});
        req = 4'b0000; channel_clear = 1'b1;
        repeat (2) @(negedge clk);
        checkEq("t3Release", grant, 4'b0000);
`endif

        // DATA with a busy channel is aborted by the guard window, then retries next frame.
        @(negedge clk);
        channel_clear = 1'b0;
        n = 0;
        while (curSlot != 16'd1 && n < 600) begin @(negedge clk); n++; end
        checkEq("t4Slot1", curSlot, 16'd1);
        req = 4'b0010;
        n = 0;
        while (!(slotTick && curSlot == 16'd2) && n < 100) begin @(negedge clk); n++; end
        checkEq("t4TickNoGrant", {slotTick, curSlot, grant}, {1'b1, 16'd2, 4'b0000});
        n = 0;
        @(negedge clk); n++;
        checkEq("t4Grant", grant, 4'b0010);
        while (grant != 4'd0 && n < 100) begin @(negedge clk); n++; end
        checkEq("t4AbortAt", 64'(n), 64'd29);
        n = 0;
        while (grant == 4'd0 && n < 600) begin @(negedge clk); n++; end
        checkEq("t4Restart", {grant, curSlot}, {4'b0010, 16'd2});
        expQ.push_back(mkEvt(4'd1, 4'b0010, 3'b101));
        channel_clear = 1'b1;
        n = 0;
        while (!tx_start && n < 10) begin @(negedge clk); n++; end
        checkEq("t4Start", tx_start, 1'b1);

        // Reset in SEND; a late tx_done is then ignored.
        @(negedge clk);
        nrst = 1'b0; req = 4'b0000;
        @(negedge clk);
        checkEq("t6Rst", {grant, tx_start, tx_type, done, fail, slotTick, curSlot}, 64'd0);
        nrst = 1'b1; tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (done != 4'd0 || grant != 4'd0) n++;
        end
        checkEq("t6NoDone", 64'(n), 64'd0);

        // Slot wrap 15 -> 0, then commPhase drop clears the timer.
        n = 0;
        while (curSlot != 16'd15 && n < 600) begin @(negedge clk); n++; end
        checkEq("t5Reach15", curSlot, 16'd15);
        @(negedge clk);
        n = 0;
        while (!slotTick && n < 40) begin @(negedge clk); n++; end
        checkEq("t5Wrap", {slotTick, curSlot}, {1'b1, 16'd0});
        @(negedge clk);
        n = 0;
        while (!slotTick && n < 40) begin @(negedge clk); n++; end
        checkEq("t5Slot1", curSlot, 16'd1);
        commPhase = 1'b0;
        @(negedge clk);
        checkEq("t5PhaseOff", {slotTick, curSlot}, 64'd0);
        repeat (40) @(negedge clk);
        checkEq("t5Held", {slotTick, curSlot}, 64'd0);

        checkEq("sbDrained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
